// File: rtl/dice_roller_if.sv
// Button-in / face-out bundle between the dice roller and its neighbours.
// Latency: none (wires only).
// Backpressure: none; the face output is a level that the display samples freely.
//
// Signals:
//   btn     raw push-button level (1 = pressed), asynchronous to clk
//   val     face value for the 7-segment decode: 0 = blank, 1..6 = face
//   rolling high while the face is cycling
//   done    one-cycle pulse after a result has been latched
interface dice_roller_if;
    logic       btn;
    logic [2:0] val;
    logic       rolling;
    logic       done;

    // Driver of the button / consumer of the face (board or bench).
    modport master (
        output btn,
        input  val,
        input  rolling,
        input  done
    );

    // The dice roller itself.
    modport slave (
        input  btn,
        output val,
        output rolling,
        output done
    );
endinterface

// File: rtl/dice_roller.sv
// Push-button dice: synchronise + debounce a raw button, cycle faces 1..6 while held, freeze on release.
// Latency: DEBOUNCE_CYCLES+3 clk edges from a stable button level to the state/rolling change.
// Backpressure: none; outputs are registered levels/pulses that downstream samples every cycle.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; returns everything to blank/IDLE
//   bus    dice_roller_if.slave: btn in; val[2:0], rolling, done out
module dice_roller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ROLL_DIV        = 2
) (
    input  logic         clk,
    input  logic         reset,
    dice_roller_if.slave bus
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int DIV_W = $clog2(ROLL_DIV) + 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ROLL_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        SHOW = 2'd2
    } state_e;

    // Synchroniser
    logic s1_q, s1_d;
    logic btn_s_q, btn_s_d;

    // Debouncer
    logic            btn_db_q, btn_db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Edge detect on the debounced level
    logic btn_db_prev_q, btn_db_prev_d;
    logic db_rise, db_fall;

    // Roll engine
    state_e           state_q, state_d;
    logic [2:0]       face_q, face_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    // Registered outputs so the display decode never sees a combinational glitch
    logic [2:0] val_q, val_d;
    logic       rolling_q, rolling_d;
    logic       done_q, done_d;

    // Explicit wrap 6 -> 1 so the face register can never reach 0 or 7 once rolled.
    function automatic logic [2:0] next_face(input logic [2:0] f);
        next_face = (f == 3'd6) ? 3'd1 : f + 3'd1;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and debouncer
    // ------------------------------------------------------------------
    always_comb begin
        s1_d     = bus.btn;
        btn_s_d  = s1_q;
        btn_db_d = btn_db_q;
        db_cnt_d = db_cnt_q;

        if (btn_s_q == btn_db_q) begin
            // Any return to the accepted level throws away partial progress.
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_s_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign btn_db_prev_d = btn_db_q;
    assign db_rise       = btn_db_q & ~btn_db_prev_q;
    assign db_fall       = ~btn_db_q & btn_db_prev_q;

    // ------------------------------------------------------------------
    // Roll FSM: next state, face, divider and output values
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        face_d    = face_q;
        div_cnt_d = div_cnt_q;

        case (state_q)
            IDLE: begin
                if (db_rise) begin
                    state_d   = ROLL;
                    face_d    = 3'd1;
                    div_cnt_d = '0;
                end
            end
            ROLL: begin
                if (db_fall) begin
                    // Release wins over a terminal divider count: the face freezes as shown.
                    state_d = SHOW;
                end else if (div_cnt_q == DIV_LAST) begin
                    face_d    = next_face(face_q);
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (db_rise) begin
                    // Continue from the held face; first advance is a full ROLL_DIV later.
                    state_d   = ROLL;
                    div_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                face_d    = 3'd0;
                div_cnt_d = '0;
            end
        endcase

        val_d     = (state_d == IDLE) ? 3'd0 : face_d;
        rolling_d = (state_d == ROLL);
        done_d    = (state_q == ROLL) && (state_d == SHOW);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q          <= 1'b0;
            btn_s_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            db_cnt_q      <= '0;
            btn_db_prev_q <= 1'b0;
            state_q       <= IDLE;
            face_q        <= 3'd0;
            div_cnt_q     <= '0;
            val_q         <= 3'd0;
            rolling_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            btn_s_q       <= btn_s_d;
            btn_db_q      <= btn_db_d;
            db_cnt_q      <= db_cnt_d;
            btn_db_prev_q <= btn_db_prev_d;
            state_q       <= state_d;
            face_q        <= face_d;
            div_cnt_q     <= div_cnt_d;
            val_q         <= val_d;
            rolling_q     <= rolling_d;
            done_q        <= done_d;
        end
    end

    assign bus.val     = val_q;
    assign bus.rolling = rolling_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller with DEBOUNCE_CYCLES=4, ROLL_DIV=2.
// A behavioural model (sample delay line, sliding stability window, face = f(ticks since roll start))
// is checked every cycle, and directed literal checks pin the model at key points.
module tb_dice_roller;

    localparam int D = 4;
    localparam int R = 2;

    logic clk;
    logic reset;

    dice_roller_if dif();

    dice_roller #(
        .DEBOUNCE_CYCLES (D),
        .ROLL_DIV        (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int dl[$];          // raw button samples still in flight through the synchroniser
    int win[$];         // last D synchronised levels
    int m_db;           // debounced level
    bit m_ev_rise, m_ev_fall;  // debounced change seen at the previous edge
    int m_mode;         // 0 idle, 1 roll, 2 show
    int m_n;            // edges spent in the current roll
    int m_base;         // face at the start of the current roll
    int m_face;
    int m_done;
    int m_pre;
    bit m_all_diff;

    task automatic model_reset();
        dl        = '{0, 0};
        win       = '{};
        m_db      = 0;
        m_ev_rise = 0;
        m_ev_fall = 0;
        m_mode    = 0;
        m_n       = 0;
        m_base    = 1;
        m_face    = 0;
        m_done    = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            m_done = 0;
            case (m_mode)
                0: if (m_ev_rise) begin
                    m_mode = 1; m_base = 1; m_n = 0; m_face = 1;
                end
                1: if (m_ev_fall) begin
                    m_mode = 2; m_done = 1;
                end else begin
                    m_n++;
                    m_face = ((m_base - 1 + m_n / R) % 6) + 1;
                end
                default: if (m_ev_rise) begin
                    m_mode = 1; m_base = m_face; m_n = 0;
                end
            endcase

            m_pre = dl.pop_front();
            dl.push_back(int'(dif.btn));
            win.push_back(m_pre);
            if (win.size() > D) void'(win.pop_front());
            m_ev_rise = 0;
            m_ev_fall = 0;
            if (win.size() == D) begin
                m_all_diff = 1;
                foreach (win[i]) if (win[i] == m_db) m_all_diff = 0;
                if (m_all_diff) begin
                    m_db = 1 - m_db;
                    if (m_db == 1) m_ev_rise = 1;
                    else           m_ev_fall = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("model_val",     dif.val,     (m_mode == 0) ? 0 : m_face);
            chk("model_rolling", dif.rolling, (m_mode == 1) ? 1 : 0);
            chk("model_done",    dif.done,    m_done);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    int exp_seq[14] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 1, 1};

    initial begin
        clk     = 1'b0;
        reset   = 1'b0;
        dif.btn = 1'b0;
        #1 reset = 1'b1;
        #3;
        chk("reset_val",     dif.val,     0);
        chk("reset_rolling", dif.rolling, 0);
        chk("reset_done",    dif.done,    0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Bounce: 3-cycle pulses with 1-cycle gaps never reach the debounce limit.
        for (int k = 0; k < 4; k++) begin
            dif.btn = 1'b1;
            repeat (3) @(negedge clk);
            chk("bounce_no_roll", dif.rolling, 0);
            dif.btn = 1'b0;
            @(negedge clk);
        end

        // Stable press: rolling rises at edge 7.
        dif.btn = 1'b1;
        repeat (6) @(negedge clk);
        chk("press_edge6_rolling", dif.rolling, 0);
        chk("press_edge6_val",     dif.val,     0);
        @(negedge clk);
        chk("press_edge7_rolling", dif.rolling, 1);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            chk("roll_seq", dif.val, exp_seq[i]);
        end

        // Now after edge 20; edge 25 shows the first cycle of face 4.
        repeat (5) @(negedge clk);
        chk("release_at_val", dif.val, 4);
        dif.btn = 1'b0;
        repeat (6) @(negedge clk);
        chk("release_edge6_rolling", dif.rolling, 1);
        chk("release_edge6_val",     dif.val,     1);
        @(negedge clk);
        chk("release_edge7_rolling", dif.rolling, 0);
        chk("release_edge7_done",    dif.done,    1);
        chk("release_frozen_val",    dif.val,     1);
        @(negedge clk);
        chk("done_one_cycle", dif.done, 0);
        repeat (100) @(negedge clk);
        chk("hold_100_val",     dif.val,     1);
        chk("hold_100_rolling", dif.rolling, 0);

        // Second roll from SHOW(1), released so that it freezes on 3.
        dif.btn = 1'b1;
        repeat (7) @(negedge clk);
        chk("reroll1_rolling", dif.rolling, 1);
        chk("reroll1_val",     dif.val,     1);
        repeat (10) @(negedge clk);
        dif.btn = 1'b0;
        repeat (7) @(negedge clk);
        chk("freeze3_done", dif.done, 1);
        chk("freeze3_val",  dif.val,  3);
        repeat (5) @(negedge clk);

        // Re-roll from SHOW(3): face continues from 3, no restart at 1.
        dif.btn = 1'b1;
        repeat (7) @(negedge clk);
        chk("reroll3_rolling", dif.rolling, 1);
        chk("reroll3_first",   dif.val,     3);
        @(negedge clk);
        chk("reroll3_second", dif.val, 3);
        @(negedge clk);
        chk("reroll3_advance", dif.val, 4);
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-roll, between clock edges.
        #2 reset = 1'b1;
        #1;
        chk("midroll_reset_val",     dif.val,     0);
        chk("midroll_reset_rolling", dif.rolling, 0);
        chk("midroll_reset_done",    dif.done,    0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Button still held: full latency again, face restarts at 1.
        repeat (6) @(negedge clk);
        chk("postreset_edge6_rolling", dif.rolling, 0);
        @(negedge clk);
        chk("postreset_edge7_rolling", dif.rolling, 1);
        chk("postreset_edge7_val",     dif.val,     1);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
